// File: rtl/acc_cpu.sv
// acc_cpu: multi-cycle accumulator CPU on a single-master bus with wait states.
// Define ACC_CPU_CALL_EN to add a link register with CALL (E) and RET (F).
module acc_cpu #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock_25,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wr,
  output logic              o_halt
);

  localparam logic [2:0] FETCH = 3'd0, OPLO = 3'd1, OPHI = 3'd2, MEM = 3'd3, HALT = 3'd4;

  localparam logic [3:0] OP_LDI = 4'h1, OP_LDA = 4'h2, OP_STA = 4'h3, OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7, OP_XOR = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JC  = 4'hB, OP_INC = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hD;
`ifdef ACC_CPU_CALL_EN
  localparam logic [3:0] OP_CALL = 4'hE, OP_RET = 4'hF;
`endif

  logic [2:0]          state;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   target;
  logic [DATA_W-1:0]   a;
  logic [DATA_W-1:0]   lo;
  logic [3:0]          op;
  logic                z;
  logic                c;
  logic [2*DATA_W-1:0] operand;
  logic [DATA_W:0]     inc_sum;
  logic [DATA_W:0]     alu_res;
  logic                take;
`ifdef ACC_CPU_CALL_EN
  logic [ADDR_W-1:0]   lr;
`endif

  function automatic logic has_operand(input logic [3:0] opc);
`ifdef ACC_CPU_CALL_EN
    return (opc >= OP_LDI && opc <= OP_JC) || opc == OP_CALL;
`else
    return opc >= OP_LDI && opc <= OP_JC;
`endif
  endfunction

  function automatic logic is_jump(input logic [3:0] opc);
`ifdef ACC_CPU_CALL_EN
    return opc == OP_JMP || opc == OP_JZ || opc == OP_JC || opc == OP_CALL;
`else
    return opc == OP_JMP || opc == OP_JZ || opc == OP_JC;
`endif
  endfunction

  // Returns {carry, result}; SUB reports carry as "no borrow".
  function automatic logic [DATA_W:0] alu(input logic [3:0] opc, input logic [DATA_W-1:0] acc,
                                          input logic [DATA_W-1:0] d, input logic cin);
    logic [DATA_W:0] r;
    case (opc)
      OP_ADD: r = {1'b0, acc} + {1'b0, d};
      OP_SUB: begin
        r = {1'b0, acc} - {1'b0, d};
        r[DATA_W] = ~r[DATA_W];
      end
      OP_AND: r = {cin, acc & d};
      OP_OR:  r = {cin, acc | d};
      OP_XOR: r = {cin, acc ^ d};
      OP_LDA: r = {cin, d};
      default: r = {cin, acc};
    endcase
    return r;
  endfunction

  // The high operand word is consumed straight off the bus at OPHI; o_addr keeps
  // the full operand address through MEM.
  assign operand = {i_data, lo};
  assign target  = operand[ADDR_W-1:0];
  assign pc_inc  = pc + ADDR_W'(1);
  assign inc_sum = {1'b0, a} + (DATA_W+1)'(1);
  assign alu_res = alu(op, a, i_data, c);
  assign o_data  = a;

  always_comb begin
    take = 1'b0;
    case (op)
      OP_JMP:  take = 1'b1;
      OP_JZ:   take = z;
      OP_JC:   take = c;
`ifdef ACC_CPU_CALL_EN
      OP_CALL: take = 1'b1;
`endif
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      a      <= '0;
      z      <= 1'b0;
      c      <= 1'b0;
      lo     <= '0;
      op     <= '0;
      o_addr <= RESET_PC;
      o_wr   <= 1'b0;
      o_halt <= 1'b0;
`ifdef ACC_CPU_CALL_EN
      lr     <= '0;
`endif
    end else if (i_ready && state != HALT) begin
      case (state)
        // fetch: latch opcode, run implied ops
        FETCH: begin
          op <= i_data[3:0];
          pc <= pc_inc;
          case (i_data[3:0])
            OP_HLT: begin
              state  <= HALT;
              o_halt <= 1'b1;
            end
            OP_INC: begin
              {c, a} <= inc_sum;
              z      <= inc_sum[DATA_W-1:0] == '0;
              o_addr <= pc_inc;
            end
`ifdef ACC_CPU_CALL_EN
            OP_RET: begin
              pc     <= lr;
              o_addr <= lr;
            end
`endif
            default: begin
              o_addr <= pc_inc;
              if (has_operand(i_data[3:0])) state <= OPLO;
            end
          endcase
        end
        // low operand word / immediate
        OPLO: begin
          lo     <= i_data;
          pc     <= pc_inc;
          o_addr <= pc_inc;
          if (op == OP_LDI) begin
            a     <= i_data;
            z     <= i_data == '0;
            state <= FETCH;
          end else begin
            state <= OPHI;
          end
        end
        // high operand word: resolve jumps or set up the memory access
        OPHI: begin
          state <= FETCH;
          if (is_jump(op)) begin
            pc     <= take ? target : pc_inc;
            o_addr <= take ? target : pc_inc;
`ifdef ACC_CPU_CALL_EN
            if (op == OP_CALL) lr <= pc_inc;
`endif
          end else begin
            pc     <= pc_inc;
            o_addr <= target;
            o_wr   <= op == OP_STA;
            state  <= MEM;
          end
        end
        // data access
        MEM: begin
          o_wr   <= 1'b0;
          o_addr <= pc;
          state  <= FETCH;
          if (op != OP_STA) begin
            {c, a} <= alu_res;
            z      <= alu_res[DATA_W-1:0] == '0;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu.sv
// Bench for acc_cpu: instruction-level reference model feeds an expected bus-cycle queue,
// a monitor compares every completed bus cycle and checks stretches and halt behaviour.
module tb_acc_cpu;
  logic        clock_25 = 1'b0;
  logic        reset    = 1'b1;
  logic [7:0]  i_data;
  logic        i_ready  = 1'b1;
  logic [15:0] o_addr;
  logic [7:0]  o_data;
  logic        o_wr;
  logic        o_halt;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  data;
  } bus_t;

  bus_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;
  bit         mon_en = 1'b0;
  bit         model_halted;
  logic [7:0] model_a;

  acc_cpu #(.DATA_W(8), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clock_25(clock_25), .reset(reset), .i_data(i_data), .i_ready(i_ready),
    .o_addr(o_addr), .o_data(o_data), .o_wr(o_wr), .o_halt(o_halt)
  );

  always #5 clock_25 = ~clock_25;

  assign i_data = mem[o_addr];
  always @(posedge clock_25) if (!reset && o_wr && i_ready) mem[o_addr] = o_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: one comparison per completed bus cycle, plus hold checks on stretched cycles.
  logic [15:0] prev_addr;
  logic        prev_wr;
  logic [7:0]  prev_data;
  bit          prev_stall = 1'b0;
  always @(negedge clock_25) begin
    bus_t e;
    if (reset || !mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stretch_hold", 32'({o_addr, o_wr, o_data}), 32'({prev_addr, prev_wr, prev_data}));
      if (o_halt) begin
        chk("halt_wr_low", 32'(o_wr), 32'(0));
      end else if (i_ready) begin
        chk("bus_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("bus_cycle", 32'({o_addr, o_wr, o_data}), 32'(e));
        end
      end
      prev_stall = !o_halt && !i_ready;
      prev_addr  = o_addr;
      prev_wr    = o_wr;
      prev_data  = o_data;
    end
  end

  task automatic push(input logic [15:0] addr, input logic wr, input logic [7:0] data);
    bus_t e;
    e.addr = addr;
    e.wr   = wr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Instruction-level interpreter: each instruction emits its bus cycles; o_data shows A
  // as it was when the instruction started.
  task automatic run_model(input int max_instr);
    logic [15:0] pc, ea, lr;
    logic [7:0]  a, a0, lo, hi, d;
    logic [3:0]  opc;
    bit          z, c;
    int          s;
    pc = 16'h0000; a = 8'h00; z = 1'b0; c = 1'b0; lr = 16'h0000;
    model_halted = 1'b0;
    for (int n = 0; n < max_instr && !model_halted; n++) begin
      a0  = a;
      d   = ref_mem[pc];
      opc = d[3:0];
      push(pc, 1'b0, a0);
      pc++;
      case (opc)
        4'hC: begin s = int'(a) + 1; c = s > 255; a = 8'(s); z = (a == 8'h00); end
        4'hD: model_halted = 1'b1;
        4'h1: begin push(pc, 1'b0, a0); a = ref_mem[pc]; pc++; z = (a == 8'h00); end
`ifdef ACC_CPU_CALL_EN
        4'hF: pc = lr;
        4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hE: begin
`else
        4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: begin
`endif
          lo = ref_mem[pc]; push(pc, 1'b0, a0); pc++;
          hi = ref_mem[pc]; push(pc, 1'b0, a0); pc++;
          ea = {hi, lo};
          if (opc == 4'h9) pc = ea;
          else if (opc == 4'hA) begin if (z) pc = ea; end
          else if (opc == 4'hB) begin if (c) pc = ea; end
          else if (opc == 4'hE) begin lr = pc; pc = ea; end
          else if (opc == 4'h3) begin push(ea, 1'b1, a0); ref_mem[ea] = a; end
          else begin
            d = ref_mem[ea];
            push(ea, 1'b0, a0);
            case (opc)
              4'h2: a = d;
              4'h4: begin s = int'(a) + int'(d); c = s > 255; a = 8'(s); end
              4'h5: begin c = (a >= d); a = a - d; end
              4'h6: a = a & d;
              4'h7: a = a | d;
              default: a = a ^ d;
            endcase
            z = (a == 8'h00);
          end
        end
        default: ;
      endcase
    end
    model_a = a;
  endtask

  task automatic fill(input bit rnd);
    logic [7:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = rnd ? 8'($urandom) : 8'h00;
      mem[i] = v;
      ref_mem[i] = v;
    end
  endtask

  task automatic poke(input logic [15:0] addr, input logic [7:0] v);
    mem[addr] = v;
    ref_mem[addr] = v;
  endtask

  // mode 0: no wait states; 1: random wait states; 2: three waits when o_addr==stall_at
  task automatic run_prog(input int mode, input logic [15:0] stall_at, input int max_instr);
    int          cyc, stalls, t0, t1;
    logic [15:0] ha;
    run_model(max_instr);
    @(posedge clock_25); #1;
    chk("reset_state", 32'({o_addr, o_wr, o_data, o_halt}), 32'({16'h0000, 1'b0, 8'h00, 1'b0}));
    mon_en = 1'b1;
    reset  = 1'b0;
    cyc = 0; stalls = 0; t0 = -1; t1 = -1;
    while (exp_q.size() != 0 && cyc < 5000) begin
      if (mode == 2 && cyc == 6) chk("a_after_6_cycles", 32'(o_data), 32'h03);
      if (o_addr == stall_at - 16'd2 && t0 < 0) t0 = cyc;
      if (o_addr == stall_at + 16'd1 && t1 < 0) t1 = cyc;
      if (mode == 0) i_ready = 1'b1;
      else if (mode == 1) i_ready = ($urandom_range(0, 3) != 0);
      else if (o_addr == stall_at && stalls < 3) begin i_ready = 1'b0; stalls++; end
      else i_ready = 1'b1;
      @(posedge clock_25); #1;
      cyc++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    if (mode == 2) chk("lda_stretch_cycles", 32'(t1 - t0), 32'(7));
    if (model_halted && exp_q.size() == 0) begin
      chk("halted", 32'(o_halt), 32'(1));
      chk("final_a", 32'(o_data), 32'(model_a));
      ha = o_addr;
      repeat (4) @(posedge clock_25);
      #1;
      chk("halt_hold", 32'({o_halt, o_wr, o_addr}), 32'({1'b1, 1'b0, ha}));
    end
    mon_en = 1'b0;
    reset  = 1'b1;
    exp_q.delete();
    i_ready = 1'b1;
  endtask

  initial begin
    bit seen;
    repeat (2) @(posedge clock_25);

    // directed: LDI/ADD carry, STA, JC, JZ taken and not taken, stretched LDA, E/F
    fill(1'b0);
    poke(16'h0000, 8'h01); poke(16'h0001, 8'h05);
    poke(16'h0002, 8'h04); poke(16'h0003, 8'h00); poke(16'h0004, 8'h01);
    poke(16'h0005, 8'h03); poke(16'h0006, 8'h00); poke(16'h0007, 8'h02);
    poke(16'h0008, 8'h0B); poke(16'h0009, 8'h10); poke(16'h000A, 8'h00);
    poke(16'h0010, 8'h01); poke(16'h0011, 8'h00);
    poke(16'h0012, 8'h0A); poke(16'h0013, 8'h40); poke(16'h0014, 8'h00);
    poke(16'h0040, 8'h01); poke(16'h0041, 8'h01);
    poke(16'h0042, 8'h0A); poke(16'h0043, 8'h50); poke(16'h0044, 8'h00);
    poke(16'h0045, 8'h02); poke(16'h0046, 8'h00); poke(16'h0047, 8'h01);
`ifdef ACC_CPU_CALL_EN
    poke(16'h0048, 8'h0E); poke(16'h0049, 8'h80); poke(16'h004A, 8'h00);
    poke(16'h004B, 8'h0B); poke(16'h004C, 8'h60); poke(16'h004D, 8'h00);
    poke(16'h0080, 8'h0F);
`else
    poke(16'h0048, 8'h0E); poke(16'h0049, 8'h0F);
    poke(16'h004A, 8'h0B); poke(16'h004B, 8'h60); poke(16'h004C, 8'h00);
`endif
    poke(16'h0060, 8'h0D);
    poke(16'h0100, 8'hFE);
    run_prog(2, 16'h0047, 100);

    // PC wrap through 0xFFFF in the middle of an operand
    fill(1'b0);
    poke(16'h0000, 8'h09); poke(16'h0001, 8'hFD); poke(16'h0002, 8'hFF);
    poke(16'hFFFD, 8'h01); poke(16'hFFFE, 8'h07); poke(16'hFFFF, 8'h04);
    poke(16'hFD09, 8'hFA); poke(16'h0003, 8'h0D);
    run_prog(1, 16'h0000, 50);

    // reset during a stretched STA
    fill(1'b0);
    poke(16'h0000, 8'h01); poke(16'h0001, 8'hAA);
    poke(16'h0002, 8'h03); poke(16'h0003, 8'h00); poke(16'h0004, 8'h03);
    @(posedge clock_25); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      i_ready = !o_wr;
      seen = o_wr;
      if (!seen) begin @(posedge clock_25); #1; end
    end
    chk("sta_reached", 32'(seen), 32'(1));
    repeat (3) @(posedge clock_25);
    #1;
    chk("sta_wr_held", 32'({o_wr, o_addr, o_data}), 32'({1'b1, 16'h0300, 8'hAA}));
    #3 reset = 1'b1;
    #1;
    chk("reset_drops_wr", 32'({o_wr, o_addr, o_data, o_halt}), 32'({1'b0, 16'h0000, 8'h00, 1'b0}));
    chk("sta_not_written", 32'(mem[16'h0300]), 32'(0));
    i_ready = 1'b1;
    @(posedge clock_25); #1;
    reset = 1'b0;
    chk("restart_fetch", 32'(o_addr), 32'h0000);
    @(posedge clock_25); #1;
    chk("restart_next", 32'(o_addr), 32'h0001);
    reset = 1'b1;

    // random memory images executed as programs
    for (int k = 0; k < 6; k++) begin
      fill(1'b1);
      run_prog((k < 4) ? 1 : 0, 16'h0000, 200);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
